// File: rtl/sata_prim_pkg.sv
// SATA link-layer primitive codes, dword encodings and the CONT-compression helpers
// shared by the transmit primitive generator and its junk scrambler.
package sata_prim_pkg;

  typedef enum logic [3:0] {
    P_SYNC  = 4'd0,
    P_X_RDY = 4'd1,
    P_R_RDY = 4'd2,
    P_R_IP  = 4'd3,
    P_R_OK  = 4'd4,
    P_R_ERR = 4'd5,
    P_SOF   = 4'd6,
    P_EOF   = 4'd7,
    P_WTRM  = 4'd8,
    P_HOLD  = 4'd9,
    P_HOLDA = 4'd10,
    P_DMAT  = 4'd11
  } prim_e;

  typedef enum logic [1:0] {
    CS_IDLE,
    CS_ONCE,
    CS_TWICE,
    CS_JUNK
  } cont_state_e;

  localparam logic [31:0] DW_ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] DW_CONT  = 32'h9999AA7C;
  localparam logic [31:0] DW_SYNC  = 32'hB5B5957C;
  localparam logic [31:0] DW_X_RDY = 32'h5757B57C;
  localparam logic [31:0] DW_R_RDY = 32'h4A4A957C;
  localparam logic [31:0] DW_R_IP  = 32'h5555B57C;
  localparam logic [31:0] DW_R_OK  = 32'h3535B57C;
  localparam logic [31:0] DW_R_ERR = 32'h5656B57C;
  localparam logic [31:0] DW_SOF   = 32'h3737B57C;
  localparam logic [31:0] DW_EOF   = 32'hD5D5B57C;
  localparam logic [31:0] DW_WTRM  = 32'h5858B57C;
  localparam logic [31:0] DW_HOLD  = 32'hD5D5AA7C;
  localparam logic [31:0] DW_HOLDA = 32'h9595AA7C;
  localparam logic [31:0] DW_DMAT  = 32'h3636B57C;

  function automatic logic [31:0] prim_encode(input logic [3:0] code);
    logic [31:0] dw;
    case (code)
      P_X_RDY: dw = DW_X_RDY;
      P_R_RDY: dw = DW_R_RDY;
      P_R_IP:  dw = DW_R_IP;
      P_R_OK:  dw = DW_R_OK;
      P_R_ERR: dw = DW_R_ERR;
      P_SOF:   dw = DW_SOF;
      P_EOF:   dw = DW_EOF;
      P_WTRM:  dw = DW_WTRM;
      P_HOLD:  dw = DW_HOLD;
      P_HOLDA: dw = DW_HOLDA;
      P_DMAT:  dw = DW_DMAT;
      default: dw = DW_SYNC;
    endcase
    return dw;
  endfunction

  // Frame delimiters must always be seen literally by the far end.
  function automatic logic no_cont(input logic [3:0] code);
    return (code == P_SOF) || (code == P_EOF) || (code == P_WTRM);
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[14] ^ v[12] ^ v[3]};
  endfunction

endpackage

// File: rtl/sata_junk_lfsr.sv
// 16-bit Fibonacci LFSR supplying the scrambled junk payload that follows a CONT.
module sata_junk_lfsr
  import sata_prim_pkg::*;
#(
  parameter logic [15:0] C_SEED = 16'hF0F6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        advance,
  output logic [15:0] value
);

  logic [15:0] value_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= C_SEED;
    end else if (load) begin
      value_q <= C_SEED;
    end else if (advance) begin
      value_q <= lfsr_next(value_q);
    end
  end

  assign value = value_q;

endmodule

// File: rtl/sata_tx_prim_gen.sv
// Transmit dword generator: merges upstream primitives/data, inserts ALIGN pairs,
// and CONT-compresses repeated primitives into scrambled junk.
//
// state    | meaning
// CS_IDLE  | no repeatable primitive outstanding
// CS_ONCE  | last_q sent once
// CS_TWICE | last_q sent twice; another repeat emits CONT
// CS_JUNK  | CONT sent; repeats of last_q emit junk
module sata_tx_prim_gen
  import sata_prim_pkg::*;
#(
  parameter int unsigned C_ALIGN_INTERVAL = 254,
  parameter logic [15:0] C_LFSR_SEED      = 16'hF0F6
) (
  input  logic        phyclk,
  input  logic        phyreset_n,
  input  logic        linkup,
  input  logic        tx_pop,
  input  logic        up_valid,
  input  logic        up_isprim,
  input  logic [3:0]  up_prim,
  input  logic [31:0] up_data,
  output logic        up_ready,
  output logic [31:0] txdata,
  output logic        txdatak,
  output logic        underflow
);

  localparam int CW = $clog2(C_ALIGN_INTERVAL + 1);

  logic [1:0]    rst_sync_q;
  logic          rst_n;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          second_q, second_d;
  cont_state_e   state_q, state_d;
  logic [3:0]    last_q, last_d;
  logic [31:0]   txdata_q, txdata_d;
  logic          txdatak_q, txdatak_d;
  logic          underflow_q, underflow_d;
  logic          lfsr_load, lfsr_adv;
  logic [15:0]   lfsr_val, junk;
  logic [3:0]    code;
  logic          align_due;

  // Assert asynchronously, release two phyclk edges after phyreset_n rises.
  always_ff @(posedge phyclk or negedge phyreset_n) begin
    if (!phyreset_n) rst_sync_q <= 2'b00;
    else             rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  sata_junk_lfsr #(.C_SEED(C_LFSR_SEED)) u_lfsr (
    .clk     (phyclk),
    .rst_n   (rst_n),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .value   (lfsr_val)
  );

  assign align_due = (cnt_q == CW'(C_ALIGN_INTERVAL));
  assign up_ready  = linkup & tx_pop & ~align_due;

  always_comb begin
    cnt_d       = cnt_q;
    second_d    = second_q;
    state_d     = state_q;
    last_d      = last_q;
    txdata_d    = txdata_q;
    txdatak_d   = txdatak_q;
    underflow_d = 1'b0;
    lfsr_load   = 1'b0;
    lfsr_adv    = 1'b0;
    junk        = lfsr_next(lfsr_val);
    // Empty pops and reserved codes both behave as SYNC.
    code = (up_valid && up_isprim && (up_prim <= 4'd11)) ? up_prim : P_SYNC;

    if (!linkup) begin
      txdata_d  = DW_ALIGN;
      txdatak_d = 1'b1;
      cnt_d     = '0;
      second_d  = 1'b0;
      state_d   = CS_IDLE;
      last_d    = P_SYNC;
    end else if (tx_pop) begin
      if (align_due) begin
        txdata_d  = DW_ALIGN;
        txdatak_d = 1'b1;
        second_d  = ~second_q;
        if (second_q) cnt_d = '0;
      end else begin
        cnt_d       = cnt_q + CW'(1);
        underflow_d = ~up_valid;
        if (up_valid && !up_isprim) begin
          txdata_d  = up_data;
          txdatak_d = 1'b0;
          state_d   = CS_IDLE;
        end else if (no_cont(code)) begin
          txdata_d  = prim_encode(code);
          txdatak_d = 1'b1;
          state_d   = CS_IDLE;
          last_d    = code;
        end else if ((state_q == CS_IDLE) || (code != last_q)) begin
          txdata_d  = prim_encode(code);
          txdatak_d = 1'b1;
          state_d   = CS_ONCE;
          last_d    = code;
        end else begin
          case (state_q)
            CS_ONCE: begin
              txdata_d  = prim_encode(code);
              txdatak_d = 1'b1;
              state_d   = CS_TWICE;
            end
            CS_TWICE: begin
              txdata_d  = DW_CONT;
              txdatak_d = 1'b1;
              state_d   = CS_JUNK;
              lfsr_load = 1'b1;
            end
            default: begin
              txdata_d  = {junk, ~junk};
              txdatak_d = 1'b0;
              lfsr_adv  = 1'b1;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge phyclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      second_q    <= 1'b0;
      state_q     <= CS_IDLE;
      last_q      <= P_SYNC;
      txdata_q    <= DW_ALIGN;
      txdatak_q   <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      second_q    <= second_d;
      state_q     <= state_d;
      last_q      <= last_d;
      txdata_q    <= txdata_d;
      txdatak_q   <= txdatak_d;
      underflow_q <= underflow_d;
    end
  end

  assign txdata    = txdata_q;
  assign txdatak   = txdatak_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sata_tx_prim_gen.sv
// Scoreboard bench for sata_tx_prim_gen: the driver queues hand-computed dwords,
// a monitor compares them whenever the DUT presents a new output.
module tb_sata_tx_prim_gen;

  localparam logic [31:0] ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] SYNC  = 32'hB5B5957C;
  localparam logic [31:0] CONT  = 32'h9999AA7C;
  localparam logic [31:0] HOLD  = 32'hD5D5AA7C;
  localparam logic [31:0] HOLDA = 32'h9595AA7C;
  localparam logic [31:0] SOF   = 32'h3737B57C;
  localparam logic [31:0] R_IP  = 32'h5555B57C;
  localparam logic [31:0] JUNK1 = 32'hE1ED1E12;
  localparam logic [31:0] JUNK2 = 32'hC3DB3C24;
  localparam logic [31:0] JUNK3 = 32'h87B77848;
  localparam int ALIGN_N = 254;

  logic        phyclk = 1'b0;
  logic        phyreset_n = 1'b0;
  logic        linkup = 1'b0;
  logic        tx_pop = 1'b0;
  logic        up_valid = 1'b0;
  logic        up_isprim = 1'b0;
  logic [3:0]  up_prim = 4'd0;
  logic [31:0] up_data = 32'd0;
  logic        up_ready;
  logic [31:0] txdata;
  logic        txdatak;
  logic        underflow;

  typedef struct packed {
    logic [31:0] d;
    logic        k;
    logic        uf;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          acnt = 0;
  bit          aphase = 1'b0;
  logic [31:0] last_d = ALIGN;
  logic        last_k = 1'b1;

  sata_tx_prim_gen dut (
    .phyclk     (phyclk),
    .phyreset_n (phyreset_n),
    .linkup     (linkup),
    .tx_pop     (tx_pop),
    .up_valid   (up_valid),
    .up_isprim  (up_isprim),
    .up_prim    (up_prim),
    .up_data    (up_data),
    .up_ready   (up_ready),
    .txdata     (txdata),
    .txdatak    (txdatak),
    .underflow  (underflow)
  );

  always #5 phyclk = ~phyclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a new dword appears after every edge with tx_pop or linkup low.
  initial begin
    bit   pres;
    exp_t e;
    forever begin
      @(posedge phyclk);
      pres = phyreset_n && (tx_pop || !linkup);
      #1;
      if (!phyreset_n) begin
        last_d = ALIGN;
        last_k = 1'b1;
      end
      if (pres) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: dword %h presented with nothing expected", txdata);
        end else begin
          e = sb.pop_front();
          chk("txdata", txdata, e.d);
          chk("txdatak", {31'b0, txdatak}, {31'b0, e.k});
          chk("underflow", {31'b0, underflow}, {31'b0, e.uf});
          last_d = e.d;
          last_k = e.k;
        end
      end else begin
        chk("hold_txdata", txdata, last_d);
        chk("hold_txdatak", {31'b0, txdatak}, {31'b0, last_k});
        chk("hold_underflow", {31'b0, underflow}, 32'd0);
      end
    end
  end

  // One driven cycle; ALIGN slots are predicted from the bench's own pop count.
  task automatic cyc(input logic lk, input logic pop, input logic v, input logic isp,
                     input logic [3:0] p, input logic [31:0] d, input logic [31:0] ed,
                     input logic ek, input logic euf, output bit taken);
    bit due;
    @(negedge phyclk);
    linkup = lk; tx_pop = pop; up_valid = v; up_isprim = isp; up_prim = p; up_data = d;
    due = (acnt == ALIGN_N);
    #1;
    chk("up_ready", {31'b0, up_ready}, {31'b0, lk & pop & ~due});
    taken = lk && pop && !due;
    if (!lk) begin
      sb.push_back(exp_t'{ALIGN, 1'b1, 1'b0});
      acnt = 0;
      aphase = 1'b0;
    end else if (pop) begin
      if (due) begin
        sb.push_back(exp_t'{ALIGN, 1'b1, 1'b0});
        if (aphase) acnt = 0;
        aphase = ~aphase;
      end else begin
        sb.push_back(exp_t'{ed, ek, euf});
        acnt++;
      end
    end
  endtask

  task automatic send(input logic v, input logic isp, input logic [3:0] p,
                      input logic [31:0] d, input logic [31:0] ed, input logic ek,
                      input logic euf);
    bit taken;
    do cyc(1'b1, 1'b1, v, isp, p, d, ed, ek, euf, taken); while (!taken);
  endtask

  task automatic prim(input logic [3:0] p, input logic [31:0] ed, input logic ek);
    send(1'b1, 1'b1, p, 32'h0, ed, ek, 1'b0);
  endtask

  task automatic data(input logic [31:0] d);
    send(1'b1, 1'b0, 4'd0, d, d, 1'b0, 1'b0);
  endtask

  task automatic empty_pop(input logic [31:0] ed);
    send(1'b0, 1'b0, 4'd0, 32'h0, ed, 1'b1, 1'b1);
  endtask

  task automatic idle();
    bit t;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 32'hBADBAD00, 32'h0, 1'b0, 1'b0, t);
  endtask

  task automatic link_down();
    bit t;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 1'b0, 1'b0, t);
  endtask

  task automatic do_reset();
    @(negedge phyclk);
    phyreset_n = 1'b0; linkup = 1'b0; tx_pop = 1'b0; up_valid = 1'b0;
    acnt = 0; aphase = 1'b0;
    repeat (2) @(negedge phyclk);
    phyreset_n = 1'b1;
    sb.push_back(exp_t'{ALIGN, 1'b1, 1'b0});
    repeat (3) link_down();
  endtask

  initial begin
    do_reset();

    // Repeated HOLD: HOLD, HOLD, CONT, then junk from the reloaded seed.
    prim(4'd9, HOLD, 1'b1);
    prim(4'd9, HOLD, 1'b1);
    prim(4'd9, CONT, 1'b1);
    prim(4'd9, JUNK1, 1'b0);
    prim(4'd9, JUNK2, 1'b0);

    data(32'h11111111);
    prim(4'd10, HOLDA, 1'b1);
    prim(4'd10, HOLDA, 1'b1);
    prim(4'd6, SOF, 1'b1);
    prim(4'd6, SOF, 1'b1);
    prim(4'd6, SOF, 1'b1);
    prim(4'd13, SYNC, 1'b1);
    prim(4'd14, SYNC, 1'b1);
    data(32'h22222222);

    // Empty pops: SYNC through the CONT path with a one-cycle underflow each.
    empty_pop(SYNC);
    empty_pop(SYNC);
    empty_pop(CONT);
    idle();
    idle();

    // Throttled data stream: output must hold while tx_pop is low.
    for (int i = 0; i < 6; i++) begin
      data(32'hC0DE0000 + 32'(i));
      idle();
    end

    // ALIGN pair after 254 popped dwords, next data right after.
    link_down();
    for (int i = 0; i < ALIGN_N + 2; i++) data(32'hA5000000 + 32'(i));

    // Junk run interrupted by an ALIGN pair resumes with junk, no second CONT.
    link_down();
    for (int i = 0; i < 250; i++) data(32'h5A000000 + 32'(i));
    prim(4'd3, R_IP, 1'b1);
    prim(4'd3, R_IP, 1'b1);
    prim(4'd3, CONT, 1'b1);
    prim(4'd3, JUNK1, 1'b0);
    prim(4'd3, JUNK2, 1'b0);
    prim(4'd3, JUNK3, 1'b0);

    // Reset mid-run discards the repeat history.
    prim(4'd9, HOLD, 1'b1);
    prim(4'd9, HOLD, 1'b1);
    do_reset();
    prim(4'd9, HOLD, 1'b1);
    prim(4'd9, HOLD, 1'b1);
    prim(4'd9, CONT, 1'b1);

    idle();
    idle();
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
